// File: rtl/fabric_reset_sequencer_pkg.sv
// Shared definitions for the fabric reset sequencer: state encodings and debug width.
package fabric_reset_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_WAIT_MSS  = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_DONE      = 3'd4,
    ST_SOFT      = 3'd5
  } seq_state_e;

endpackage

// File: rtl/fabric_reset_sequencer_if.sv
// Channel-side bundle of the reset sequencer: per-domain resets, handshakes and status.
interface fabric_reset_sequencer_if
  import fabric_reset_pkg::*;
#(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0]      CH_READY;
  logic [NUM_CH-1:0]      SOFT_RESET;
  logic [NUM_CH-1:0]      CH_RESET_N;
  logic                   INIT_DONE;
  logic [NUM_CH-1:0]      TIMEOUT_ERR;
  logic                   LOCK_LOST;
  logic [SEQ_STATE_W-1:0] SEQ_STATE;

  modport master (
    input  CH_READY, SOFT_RESET,
    output CH_RESET_N, INIT_DONE, TIMEOUT_ERR, LOCK_LOST, SEQ_STATE
  );

  modport slave (
    output CH_READY, SOFT_RESET,
    input  CH_RESET_N, INIT_DONE, TIMEOUT_ERR, LOCK_LOST, SEQ_STATE
  );

endinterface

// File: rtl/fabric_reset_sequencer_sync.sv
// Two-flop synchroniser for an asynchronous level (PLL lock); clears to 0 on reset.
module reset_sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/fabric_reset_sequencer.sv
// Multi-channel fabric reset sequencer: qualifies CCC lock, waits for the MSS, then
// releases each fabric reset domain in turn with a ready/timeout handshake.
module fabric_reset_sequencer
  import fabric_reset_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int LOCK_FILTER = 16,
  parameter int CH_TIMEOUT  = 64,
  parameter int SOFT_HOLD   = 8,
  parameter int CNT_W       = 8
) (
  input  logic CLK_BASE,
  input  logic FAB_RESET_N,
  input  logic PLL_LOCK,
  input  logic MSS_RESET_N_M2F,
  fabric_reset_sequencer_if.master bus
);

  localparam int               IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(CH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  seq_state_e        r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx, w_cnt_inc;
  logic [IDX_W-1:0]  r_idx, w_idx_nx;
  logic [NUM_CH-1:0] r_ch_rst_n, w_ch_rst_n_nx;
  logic [NUM_CH-1:0] r_mask, w_mask_nx;
  logic [NUM_CH-1:0] r_terr, w_terr_nx;
  logic              r_init_done, w_init_done_nx;
  logic              r_lock_lost, w_lock_lost_nx;
  logic              w_lock_s;
  logic              w_ready;

  reset_sync_2ff u_lock_sync (
    .i_clk   (CLK_BASE),
    .i_rst_n (FAB_RESET_N),
    .i_d     (PLL_LOCK),
    .o_q     (w_lock_s)
  );

  // Counter saturates rather than wrapping so a stuck condition can never re-trigger.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : (r_cnt + CNT_ONE);
  assign w_ready   = bus.CH_READY[r_idx];

  always_ff @(posedge CLK_BASE) begin
    if (!FAB_RESET_N) begin
      r_state     <= ST_WAIT_LOCK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_ch_rst_n  <= '0;
      r_mask      <= '0;
      r_terr      <= '0;
      r_init_done <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_idx       <= w_idx_nx;
      r_ch_rst_n  <= w_ch_rst_n_nx;
      r_mask      <= w_mask_nx;
      r_terr      <= w_terr_nx;
      r_init_done <= w_init_done_nx;
      r_lock_lost <= w_lock_lost_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_idx_nx       = r_idx;
    w_ch_rst_n_nx  = r_ch_rst_n;
    w_mask_nx      = r_mask;
    w_terr_nx      = r_terr;
    w_init_done_nx = r_init_done;
    w_lock_lost_nx = r_lock_lost;

    // Lock loss outranks everything; an MSS drop is the same abort minus the sticky flag.
    if ((r_state != ST_WAIT_LOCK) && !w_lock_s) begin
      w_ch_rst_n_nx  = '0;
      w_init_done_nx = 1'b0;
      w_lock_lost_nx = 1'b1;
      w_idx_nx       = '0;
      w_cnt_nx       = '0;
      w_state_nx     = ST_WAIT_LOCK;
    end else if ((r_state inside {ST_RELEASE, ST_WAIT_ACK, ST_DONE, ST_SOFT}) && !MSS_RESET_N_M2F) begin
      w_ch_rst_n_nx  = '0;
      w_init_done_nx = 1'b0;
      w_idx_nx       = '0;
      w_cnt_nx       = '0;
      w_state_nx     = ST_WAIT_MSS;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          if (!w_lock_s) begin
            w_cnt_nx = '0;
          end else if (r_cnt >= LOCK_LAST) begin
            w_cnt_nx   = '0;
            w_state_nx = ST_WAIT_MSS;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        ST_WAIT_MSS: begin
          if (MSS_RESET_N_M2F) begin
            w_idx_nx   = '0;
            w_state_nx = ST_RELEASE;
          end else begin
            w_state_nx = ST_WAIT_MSS;
          end
        end
        ST_RELEASE: begin
          w_ch_rst_n_nx[r_idx] = 1'b1;
          w_cnt_nx             = '0;
          w_state_nx           = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (w_ready || (r_cnt >= ACK_LAST)) begin
            if (!w_ready) begin
              w_terr_nx[r_idx] = 1'b1;
            end else begin
              w_terr_nx = r_terr;
            end
            if (r_idx == IDX_LAST) begin
              w_state_nx = ST_DONE;
            end else begin
              w_idx_nx   = r_idx + IDX_ONE;
              w_state_nx = ST_RELEASE;
            end
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        ST_DONE: begin
          if (|bus.SOFT_RESET) begin
            w_mask_nx      = bus.SOFT_RESET;
            w_ch_rst_n_nx  = r_ch_rst_n & ~bus.SOFT_RESET;
            w_init_done_nx = 1'b0;
            w_cnt_nx       = '0;
            w_state_nx     = ST_SOFT;
          end else begin
            w_init_done_nx = 1'b1;
          end
        end
        ST_SOFT: begin
          if (r_cnt >= SOFT_LAST) begin
            w_ch_rst_n_nx = r_ch_rst_n | r_mask;
            w_cnt_nx      = '0;
            w_state_nx    = ST_DONE;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        default: begin
          w_ch_rst_n_nx  = '0;
          w_init_done_nx = 1'b0;
          w_idx_nx       = '0;
          w_cnt_nx       = '0;
          w_state_nx     = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  assign bus.CH_RESET_N  = r_ch_rst_n;
  assign bus.INIT_DONE   = r_init_done;
  assign bus.TIMEOUT_ERR = r_terr;
  assign bus.LOCK_LOST   = r_lock_lost;
  assign bus.SEQ_STATE   = r_state;

endmodule

// File: tb/tb_fabric_reset_sequencer.sv
// Self-checking bench: expected timelines are computed arithmetically from the
// sequencing rules (lock filter, two cycles per ready channel, timeout, soft hold).
module tb_fabric_reset_sequencer;
  import fabric_reset_pkg::*;

  localparam int N  = 4;
  localparam int LF = 16;
  localparam int TO = 64;
  localparam int SH = 8;
  localparam int VW = 2 * N + 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pll   = 1'b0;
  logic mss   = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] terr_base = '0;
  logic         lost_exp  = 1'b0;

  fabric_reset_sequencer_if #(.NUM_CH(N)) bus ();

  fabric_reset_sequencer #(
    .NUM_CH(N), .LOCK_FILTER(LF), .CH_TIMEOUT(TO), .SOFT_HOLD(SH), .CNT_W(8)
  ) dut (
    .CLK_BASE        (clk),
    .FAB_RESET_N     (rst_n),
    .PLL_LOCK        (pll),
    .MSS_RESET_N_M2F (mss),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pll = 1'b0; mss = 1'b0;
    bus.CH_READY = '0; bus.SOFT_RESET = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    terr_base = '0;
    lost_exp  = 1'b0;
  endtask

  // Edge k=1 is the first edge after the call; m is the edge that enters WAIT_MSS
  // (0 when resuming from WAIT_MSS), channel i is released at edge r[i].
  task automatic seq_run(input string tag, input int glitch_at, input logic [N-1:0] rdy,
                         input int late_ch, input int stop_k, input bit resume);
    int r [N+1];
    int m, last;
    logic [2:0] est;
    logic [N-1:0] err_bits, exp_ch, exp_terr;
    logic [VW-1:0] got, exp;
    m    = resume ? 0 : (glitch_at + LF + 2);
    r[0] = m + 2;
    err_bits = '0;
    for (int i = 0; i < N; i++) begin
      r[i+1] = r[i] + (rdy[i] ? 2 : TO + 1);
      if (!rdy[i] && i != late_ch) err_bits[i] = 1'b1;
    end
    last = (stop_k > 0) ? stop_k : r[N] + 2;
    bus.CH_READY = rdy;
    mss = 1'b1;
    if (!resume) pll = (glitch_at == 1) ? 1'b0 : 1'b1;
    for (int k = 1; k <= last; k++) begin
      tick();
      if (k < m) est = 3'd0;
      else if (k == m) est = 3'd1;
      else if (k >= r[N] - 1) est = 3'd4;
      else begin
        est = 3'd3;
        for (int i = 0; i < N; i++) if (k == r[i] - 1) est = 3'd2;
      end
      for (int i = 0; i < N; i++) begin
        exp_ch[i]   = (k >= r[i]);
        exp_terr[i] = terr_base[i] | (err_bits[i] & (k >= r[i] + TO));
      end
      exp = {est, exp_ch, (k >= r[N]), exp_terr, lost_exp};
      got = {bus.SEQ_STATE, bus.CH_RESET_N, bus.INIT_DONE, bus.TIMEOUT_ERR, bus.LOCK_LOST};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s k=%0d got {st,ch,init,terr,lost}=%b expected %b", tag, k, got, exp);
      end
      if (!resume) pll = (k + 1 == glitch_at) ? 1'b0 : 1'b1;
      if (late_ch >= 0 && k == r[late_ch] + TO - 1) bus.CH_READY[late_ch] = 1'b1;
    end
    if (stop_k == 0) terr_base = terr_base | err_bits;
  endtask

  task automatic test_reset();
    logic [VW-1:0] got;
    rst_n = 1'b0; pll = 1'b1; mss = 1'b1;
    bus.CH_READY = '1; bus.SOFT_RESET = '0;
    repeat (3) tick();
    got = {bus.SEQ_STATE, bus.CH_RESET_N, bus.INIT_DONE, bus.TIMEOUT_ERR, bus.LOCK_LOST};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_values got %b expected %b", got, {VW{1'b0}});
    end
    do_reset();
    seq_run("pre_reset", 0, '1, -1, 23, 1'b0);
    rst_n = 1'b0;
    tick();
    got = {bus.SEQ_STATE, bus.CH_RESET_N, bus.INIT_DONE, bus.TIMEOUT_ERR, bus.LOCK_LOST};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL mid_seq_reset got %b expected %b", got, {VW{1'b0}});
    end
    tick();
    rst_n = 1'b1;
    terr_base = '0;
    lost_exp  = 1'b0;
    seq_run("post_reset", 0, '1, -1, 0, 1'b0);
  endtask

  task automatic test_soft(input string tag, input logic [N-1:0] mask, input logic [N-1:0] second);
    logic [VW-1:0] got, exp;
    bit in_soft;
    bus.SOFT_RESET = mask;
    for (int k = 1; k <= SH + 3; k++) begin
      tick();
      in_soft = (k < 1 + SH);
      exp = {(in_soft ? 3'd5 : 3'd4), (in_soft ? ~mask : {N{1'b1}}), (k >= SH + 2), terr_base, lost_exp};
      got = {bus.SEQ_STATE, bus.CH_RESET_N, bus.INIT_DONE, bus.TIMEOUT_ERR, bus.LOCK_LOST};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s k=%0d got {st,ch,init,terr,lost}=%b expected %b", tag, k, got, exp);
      end
      bus.SOFT_RESET = (k == 3) ? second : '0;
    end
  endtask

  task automatic test_lock_loss();
    logic [VW-1:0] got, exp;
    bit drop;
    pll = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      drop = (k >= 3);
      exp = {(drop ? 3'd0 : 3'd4), {N{~drop}}, ~drop, terr_base, (drop | lost_exp)};
      got = {bus.SEQ_STATE, bus.CH_RESET_N, bus.INIT_DONE, bus.TIMEOUT_ERR, bus.LOCK_LOST};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL lock_loss k=%0d got {st,ch,init,terr,lost}=%b expected %b", k, got, exp);
      end
    end
    lost_exp = 1'b1;
    seq_run("relock", 0, '1, -1, 0, 1'b0);
  endtask

  task automatic test_mss();
    logic [VW-1:0] got, exp;
    do_reset();
    seq_run("mss_pre", 0, 4'b1101, -1, LF + 2 + 4 + 5, 1'b0);
    mss = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp = {3'd1, {N{1'b0}}, 1'b0, terr_base, lost_exp};
      got = {bus.SEQ_STATE, bus.CH_RESET_N, bus.INIT_DONE, bus.TIMEOUT_ERR, bus.LOCK_LOST};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mss_drop k=%0d got {st,ch,init,terr,lost}=%b expected %b", k, got, exp);
      end
    end
    seq_run("mss_resume", 0, '1, -1, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [N-1:0] rdy, mask;
    int g, late, pick;
    for (int it = 0; it < 4; it++) begin
      rdy  = N'($urandom);
      g    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LF)) : 0;
      pick = int'($urandom_range(0, N - 1));
      late = rdy[pick] ? -1 : pick;
      do_reset();
      seq_run("rand_seq", g, rdy, late, 0, 1'b0);
      bus.CH_READY = '1;
      mask = N'($urandom_range(1, (1 << N) - 1));
      test_soft("rand_soft", mask, N'($urandom));
    end
  endtask

  initial begin
    test_reset();
    do_reset();
    seq_run("lock_qual", 0, '1, -1, 0, 1'b0);
    test_soft("soft_1010", 4'b1010, 4'b0001);
    test_lock_loss();
    do_reset();
    seq_run("lock_glitch", 11, '1, -1, 0, 1'b0);
    do_reset();
    seq_run("ch2_timeout", 0, 4'b1011, -1, 0, 1'b0);
    do_reset();
    seq_run("ready_at_timeout", 0, 4'b1011, 2, 0, 1'b0);
    test_mss();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
